// File: rtl/afu_mmio_slave.sv
// afu_mmio_slave: PSL MMIO slave serving AFU descriptor and problem-state registers.
// Optional build macro MMIO_PARITY_CHECK_EN enables request parity checking.
module afu_mmio_slave #(
   parameter int ACK_DELAY = 1
) (
   input  logic        ha_pclock,
   input  logic        ha_rst_n,
   input  logic        ha_mmval,
   input  logic        ha_mmcfg,
   input  logic        ha_mmrnw,
   input  logic        ha_mmdw,
   input  logic [0:23] ha_mmad,
   input  logic        ha_mmadpar,
   input  logic [0:63] ha_mmdata,
   input  logic        ha_mmdatapar,
   output logic        ah_mmack,
   output logic [0:63] ah_mmdata,
   output logic        ah_mmdatapar
);

   localparam int NST = ACK_DELAY + 2;
   localparam logic [0:63] AFU_DESC0 = 64'h0000_0001_0000_8010;
   localparam logic [0:63] AFU_ID    = 64'h4341_5049_5F41_4655;

   logic [0:22] idx;
   logic        wsel;
   logic        par_err;
   logic        ps_wr;
   logic        commit;
   logic [0:63] scratch0;
   logic [0:63] scratch1;
   logic [0:63] wrcount;
   logic [0:63] rd_dw;
   logic [0:63] resp;
   logic [0:63] wr_val0;
   logic [0:63] wr_val1;

   logic        ack_q [NST];
   logic [0:63] dat_q [NST];
   logic        par_q [NST];

   assign idx  = ha_mmad[0:22];
   assign wsel = ha_mmad[23];

`ifdef MMIO_PARITY_CHECK_EN
   logic status_err;

   assign par_err = ha_mmval &
                    ((ha_mmadpar != ~^ha_mmad) |
                     (~ha_mmrnw & (ha_mmdatapar != ~^ha_mmdata)));
`else
   logic unused_par;

   assign unused_par = ha_mmadpar ^ ha_mmdatapar;
   assign par_err    = 1'b0;
`endif

   assign ps_wr  = ha_mmval & ~ha_mmrnw & ~ha_mmcfg;
   assign commit = ps_wr & ~par_err;

   // Word writes replace only the selected half, taken from the same half of the bus.
   function automatic logic [0:63] merge(
      input logic [0:63] old,
      input logic [0:63] data,
      input logic        dw,
      input logic        sel
   );
      if (dw)
         return data;
      else if (sel)
         return {old[0:31], data[32:63]};
      else
         return {data[0:31], old[32:63]};
   endfunction

   assign wr_val0 = merge(scratch0, ha_mmdata, ha_mmdw, wsel);
   assign wr_val1 = merge(scratch1, ha_mmdata, ha_mmdw, wsel);

   always_comb begin
      rd_dw = '0;
      if (ha_mmcfg) begin
         if (idx == 23'd0)
            rd_dw = AFU_DESC0;
      end else begin
         case (idx)
            23'd0: rd_dw = AFU_ID;
            23'd1: rd_dw = scratch0;
            23'd2: rd_dw = scratch1;
`ifdef MMIO_PARITY_CHECK_EN
            23'd3: rd_dw = {63'b0, status_err};
`endif
            23'd4: rd_dw = wrcount;
            default: rd_dw = '0;
         endcase
      end
   end

   always_comb begin
      resp = '0;
      if (ha_mmval & ha_mmrnw & ~par_err) begin
         if (ha_mmdw)
            resp = rd_dw;
         else if (wsel)
            resp = {rd_dw[32:63], rd_dw[32:63]};
         else
            resp = {rd_dw[0:31], rd_dw[0:31]};
      end
   end

   always_ff @(posedge ha_pclock or negedge ha_rst_n) begin
      if (!ha_rst_n) begin
         scratch0 <= '0;
         scratch1 <= '0;
         wrcount  <= '0;
      end else if (commit) begin
         if (idx == 23'd1)
            scratch0 <= wr_val0;
         if (idx == 23'd2)
            scratch1 <= wr_val1;
         if (idx == 23'd1 || idx == 23'd2)
            wrcount <= wrcount + 64'd1;
      end
   end

`ifdef MMIO_PARITY_CHECK_EN
   // A bad-parity write to STATUS must not clear the error it just raised.
   always_ff @(posedge ha_pclock or negedge ha_rst_n) begin
      if (!ha_rst_n)
         status_err <= 1'b0;
      else if (par_err)
         status_err <= 1'b1;
      else if (ps_wr && idx == 23'd3)
         status_err <= 1'b0;
   end
`endif

   always_ff @(posedge ha_pclock or negedge ha_rst_n) begin
      if (!ha_rst_n) begin
         for (int i = 0; i < NST; i++) begin
            ack_q[i] <= 1'b0;
            dat_q[i] <= '0;
            par_q[i] <= 1'b1;
         end
      end else begin
         ack_q[0] <= ha_mmval;
         dat_q[0] <= resp;
         par_q[0] <= ~^resp;
         for (int i = 1; i < NST; i++) begin
            ack_q[i] <= ack_q[i-1];
            dat_q[i] <= dat_q[i-1];
            par_q[i] <= par_q[i-1];
         end
      end
   end

   assign ah_mmack     = ack_q[NST-1];
   assign ah_mmdata    = dat_q[NST-1];
   assign ah_mmdatapar = par_q[NST-1];

endmodule

// File: tb/tb_afu_mmio_slave.sv
// tb_afu_mmio_slave: directed checks of afu_mmio_slave latency, registers and reset.
// Parity-error expectations follow MMIO_PARITY_CHECK_EN when it is defined.
module tb_afu_mmio_slave;

   logic        ha_pclock = 1'b0;
   logic        ha_rst_n;
   logic        ha_mmval;
   logic        ha_mmcfg;
   logic        ha_mmrnw;
   logic        ha_mmdw;
   logic [0:23] ha_mmad;
   logic        ha_mmadpar;
   logic [0:63] ha_mmdata;
   logic        ha_mmdatapar;
   logic        ah_mmack;
   logic [0:63] ah_mmdata;
   logic        ah_mmdatapar;

   int n_run  = 0;
   int n_fail = 0;

   localparam logic [0:63] DESC0 = 64'h0000_0001_0000_8010;
   localparam logic [0:63] ID    = 64'h4341_5049_5F41_4655;

   always #5 ha_pclock = ~ha_pclock;

   afu_mmio_slave dut (
      .ha_pclock    (ha_pclock),
      .ha_rst_n     (ha_rst_n),
      .ha_mmval     (ha_mmval),
      .ha_mmcfg     (ha_mmcfg),
      .ha_mmrnw     (ha_mmrnw),
      .ha_mmdw      (ha_mmdw),
      .ha_mmad      (ha_mmad),
      .ha_mmadpar   (ha_mmadpar),
      .ha_mmdata    (ha_mmdata),
      .ha_mmdatapar (ha_mmdatapar),
      .ah_mmack     (ah_mmack),
      .ah_mmdata    (ah_mmdata),
      .ah_mmdatapar (ah_mmdatapar)
   );

   task automatic chk(input string tag, input logic [0:63] got,
                      input logic [0:63] exp);
      n_run++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic cfg, input logic rnw, input logic dw,
                        input logic [0:23] ad, input logic [0:63] data,
                        input logic badpar);
      ha_mmval     = 1'b1;
      ha_mmcfg     = cfg;
      ha_mmrnw     = rnw;
      ha_mmdw      = dw;
      ha_mmad      = ad;
      ha_mmadpar   = (~^ad) ^ badpar;
      ha_mmdata    = data;
      ha_mmdatapar = ~^data;
   endtask

   task automatic issue(input logic cfg, input logic rnw, input logic dw,
                        input logic [0:23] ad, input logic [0:63] data,
                        input logic badpar);
      @(negedge ha_pclock);
      drive(cfg, rnw, dw, ad, data, badpar);
      @(posedge ha_pclock);
      #1 ha_mmval = 1'b0;
   endtask

   task automatic rd(input logic cfg, input logic dw, input logic [0:23] ad,
                     input logic [0:63] exp, input string tag);
      issue(cfg, 1'b1, dw, ad, 64'd0, 1'b0);
      @(posedge ha_pclock);
      #1 chk({tag, ".early"}, {63'd0, ah_mmack}, 64'd0);
      @(posedge ha_pclock);
      #1;
      chk({tag, ".ack"}, {63'd0, ah_mmack}, 64'd1);
      chk({tag, ".data"}, ah_mmdata, exp);
      chk({tag, ".par"}, {63'd0, ah_mmdatapar}, {63'd0, ~^exp});
   endtask

   task automatic wr(input logic cfg, input logic dw, input logic [0:23] ad,
                     input logic [0:63] data, input logic badpar,
                     input string tag);
      issue(cfg, 1'b0, dw, ad, data, badpar);
      @(posedge ha_pclock);
      #1 chk({tag, ".early"}, {63'd0, ah_mmack}, 64'd0);
      @(posedge ha_pclock);
      #1 chk({tag, ".ack"}, {63'd0, ah_mmack}, 64'd1);
   endtask

   initial begin
      ha_rst_n     = 1'b0;
      ha_mmval     = 1'b0;
      ha_mmcfg     = 1'b0;
      ha_mmrnw     = 1'b0;
      ha_mmdw      = 1'b0;
      ha_mmad      = '0;
      ha_mmadpar   = 1'b0;
      ha_mmdata    = '0;
      ha_mmdatapar = 1'b0;

      repeat (2) @(posedge ha_pclock);
      #1;
      chk("rst.ack", {63'd0, ah_mmack}, 64'd0);
      chk("rst.data", ah_mmdata, 64'd0);
      chk("rst.par", {63'd0, ah_mmdatapar}, 64'd1);
      @(negedge ha_pclock);
      ha_rst_n = 1'b1;

      rd(1'b1, 1'b1, 24'd0, DESC0, "desc0");
      rd(1'b1, 1'b1, 24'd10, 64'd0, "desc5");
      rd(1'b0, 1'b1, 24'd0, ID, "id");
      rd(1'b0, 1'b1, 24'd6, 64'd0, "status0");

      wr(1'b0, 1'b1, 24'd2, 64'hDEAD_BEEF_0123_4567, 1'b0, "wr_s0");
      rd(1'b0, 1'b1, 24'd2, 64'hDEAD_BEEF_0123_4567, "rd_s0");
      rd(1'b0, 1'b1, 24'd8, 64'd1, "wrcnt1");

      wr(1'b0, 1'b0, 24'd5, 64'h1111_1111_CAFE_F00D, 1'b0, "wwr_s1");
      rd(1'b0, 1'b0, 24'd5, 64'hCAFE_F00D_CAFE_F00D, "wrd_s1");
      rd(1'b0, 1'b1, 24'd4, 64'h0000_0000_CAFE_F00D, "rd_s1");
      rd(1'b0, 1'b0, 24'd4, 64'd0, "wrd_s1lo");
      rd(1'b0, 1'b0, 24'd0, 64'h4341_5049_4341_5049, "wrd_idhi");
      rd(1'b0, 1'b1, 24'd8, 64'd2, "wrcnt2");

      wr(1'b0, 1'b1, 24'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "wr_id");
      rd(1'b0, 1'b1, 24'd0, ID, "id_ro");
      wr(1'b1, 1'b1, 24'd2, 64'h1234_5678_9ABC_DEF0, 1'b0, "wr_desc");
      rd(1'b1, 1'b1, 24'd2, 64'd0, "desc1_ro");
      wr(1'b0, 1'b1, 24'd14, 64'h5A5A_5A5A_5A5A_5A5A, 1'b0, "wr_idx7");
      rd(1'b0, 1'b1, 24'd14, 64'd0, "rd_idx7");
      rd(1'b0, 1'b1, 24'd8, 64'd2, "wrcnt_keep");

      // back-to-back reads on consecutive cycles
      @(negedge ha_pclock);
      drive(1'b0, 1'b1, 1'b1, 24'd0, 64'd0, 1'b0);
      @(posedge ha_pclock);
      #1 drive(1'b0, 1'b1, 1'b1, 24'd6, 64'd0, 1'b0);
      @(posedge ha_pclock);
      #1;
      ha_mmval = 1'b0;
      chk("b2b.early", {63'd0, ah_mmack}, 64'd0);
      @(posedge ha_pclock);
      #1;
      chk("b2b.ack0", {63'd0, ah_mmack}, 64'd1);
      chk("b2b.data0", ah_mmdata, ID);
      @(posedge ha_pclock);
      #1;
      chk("b2b.ack1", {63'd0, ah_mmack}, 64'd1);
      chk("b2b.data1", ah_mmdata, 64'd0);
      chk("b2b.par1", {63'd0, ah_mmdatapar}, 64'd1);
      @(posedge ha_pclock);
      #1;
      chk("idle.ack", {63'd0, ah_mmack}, 64'd0);
      chk("idle.data", ah_mmdata, 64'd0);
      chk("idle.par", {63'd0, ah_mmdatapar}, 64'd1);

      wr(1'b0, 1'b1, 24'd2, 64'h5555_0000_AAAA_1111, 1'b1, "wr_badpar");
`ifdef MMIO_PARITY_CHECK_EN
      rd(1'b0, 1'b1, 24'd2, 64'hDEAD_BEEF_0123_4567, "s0_kept");
      rd(1'b0, 1'b1, 24'd6, 64'd1, "status_set");
      wr(1'b0, 1'b1, 24'd6, 64'd0, 1'b1, "wr_st_bad");
      rd(1'b0, 1'b1, 24'd6, 64'd1, "status_stays");
      wr(1'b0, 1'b1, 24'd6, 64'd0, 1'b0, "wr_status");
      rd(1'b0, 1'b1, 24'd6, 64'd0, "status_clr");
      rd(1'b0, 1'b1, 24'd8, 64'd2, "wrcnt_par");
`else
      rd(1'b0, 1'b1, 24'd2, 64'h5555_0000_AAAA_1111, "s0_new");
      rd(1'b0, 1'b1, 24'd6, 64'd0, "status_off");
      rd(1'b0, 1'b1, 24'd8, 64'd3, "wrcnt_par");
`endif

      // reset one cycle after a read request drops it
      issue(1'b0, 1'b1, 1'b1, 24'd0, 64'd0, 1'b0);
      @(posedge ha_pclock);
      #1 ha_rst_n = 1'b0;
      #1;
      chk("rstq.ack", {63'd0, ah_mmack}, 64'd0);
      chk("rstq.data", ah_mmdata, 64'd0);
      chk("rstq.par", {63'd0, ah_mmdatapar}, 64'd1);
      @(posedge ha_pclock);
      #1 chk("rstq.ack1", {63'd0, ah_mmack}, 64'd0);
      @(posedge ha_pclock);
      #1 chk("rstq.ack2", {63'd0, ah_mmack}, 64'd0);
      @(negedge ha_pclock);
      ha_rst_n = 1'b1;
      @(posedge ha_pclock);
      #1 chk("rstq.ack3", {63'd0, ah_mmack}, 64'd0);
      rd(1'b0, 1'b1, 24'd2, 64'd0, "s0_rst");
      rd(1'b0, 1'b1, 24'd4, 64'd0, "s1_rst");
      rd(1'b0, 1'b1, 24'd8, 64'd0, "wrcnt_rst");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
